// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: shared 3-step fetch, then up to 5 opcode-decoded execute steps.
// Outputs are a pure combinational decode of (state, opcode, CON_FF). Stop is honoured only at an instruction boundary.
module control_sequencer #(
    parameter int         OP_MSB          = 31,
    parameter logic [4:0] ALU_ADD         = 5'b00011,
    parameter bit         HALT_ON_UNKNOWN = 1'b0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  ALUop,
    output logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout,
    output logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin,
    output logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn
);
    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01011, OP_BRZR = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     r_state, w_next, w_last;
    logic [4:0] w_op;
    logic       w_known, w_enter_halt, w_unused_ir;

    assign w_op        = IR[OP_MSB -: 5];
    assign w_unused_ir = ^IR;

    // Final step of each instruction class; the edge leaving it returns to T0 (or HALT on Stop).
    always_comb begin
        w_last  = S_T2;
        w_known = 1'b1;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: w_last = S_T5;
            OP_LD, OP_ST:                                   w_last = S_T7;
            OP_BRZR:                                        w_last = S_T6;
            OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT:         w_last = S_T3;
            OP_NOP, OP_HALT:                                w_last = S_T2;
            default:                                        w_known = 1'b0;
        endcase
    end

    assign w_enter_halt = (w_op == OP_HALT) || (!w_known && HALT_ON_UNKNOWN);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_HALT:  w_next = S_HALT;
            default: begin
                if (r_state == S_T2 && w_enter_halt) w_next = S_HALT;
                else if (r_state == w_last)          w_next = Stop ? S_HALT : S_T0;
                else                                 w_next = state_t'(r_state + 4'd1);
            end
        endcase
    end

    always_comb begin
        Run = (r_state != S_RESET) && (r_state != S_HALT);
        ALUop = 5'd0;
        {PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin}           = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn} = '0;
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                                  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_LDI, OP_LD, OP_ST:
                                  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_BRZR:      begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
                    OP_JR:        begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_MFHI:      begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO:      begin LOWout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_IN:        begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:       begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR:
                        begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = w_op; end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST:
                        begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    OP_BRZR: begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                              begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    OP_BRZR:  begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_op)
                    OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    // Branch taken only when the condition flop is set during this step.
                    OP_BRZR: begin Zlowout = 1'b1; PCin = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_op)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written interrupt sequences, and
// randomized instruction streams checked against a per-opcode recipe model.
module tb_control_sequencer;
    logic        Clock = 1'b0;
    logic        Clear, CON_FF, Stop;
    logic [31:0] IR;
    logic        Run;
    logic [4:0]  ALUop;
    logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin;
    logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn;
    logic [30:0] w_ctl;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
    localparam logic [4:0] SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01011;
    localparam logic [4:0] BRZR = 5'b10010, JR = 5'b10011, IN_ = 5'b10110, OUT_ = 5'b10111;
    localparam logic [4:0] MFHI = 5'b11000, MFLO = 5'b11001, NOP = 5'b11010, HALT = 5'b11011;

    localparam logic [30:0] M_PCOUT = 31'd1 << 0,  M_ZHIOUT = 31'd1 << 1,  M_ZLOWOUT = 31'd1 << 2;
    localparam logic [30:0] M_MDROUT = 31'd1 << 3, M_HIOUT = 31'd1 << 4,   M_LOWOUT = 31'd1 << 5;
    localparam logic [30:0] M_INPORTOUT = 31'd1 << 6, M_MARIN = 31'd1 << 7, M_ZIN = 31'd1 << 8;
    localparam logic [30:0] M_PCIN = 31'd1 << 9,   M_MDRIN = 31'd1 << 10,  M_IRIN = 31'd1 << 11;
    localparam logic [30:0] M_YIN = 31'd1 << 12,   M_OUTPORTIN = 31'd1 << 13, M_INCPC = 31'd1 << 14;
    localparam logic [30:0] M_READ = 31'd1 << 15,  M_WRITE = 31'd1 << 16,  M_GRA = 31'd1 << 17;
    localparam logic [30:0] M_GRB = 31'd1 << 18,   M_GRC = 31'd1 << 19,    M_RIN = 31'd1 << 20;
    localparam logic [30:0] M_ROUT = 31'd1 << 21,  M_BAOUT = 31'd1 << 22,  M_COUT = 31'd1 << 23;
    localparam logic [30:0] M_CONIN = 31'd1 << 24, M_RUN = 31'd1 << 25;
    localparam logic [30:0] T0W = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .ALUop(ALUop),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
        .LOWout(LOWout), .InPortout(InPortout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONIn(CONIn)
    );

    assign w_ctl = {ALUop, Run, CONIn, Cout, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC,
                    OutPortin, Yin, IRin, MDRin, PCin, Zin, MARin, InPortout, LOWout, HIout,
                    MDRout, Zlowout, Zhiout, PCout};

    always #5 Clock = ~Clock;

    function automatic logic [30:0] alu(input logic [4:0] op);
        return {op, 26'd0};
    endfunction

    // Index of the final step (2..7) for each instruction; halt is handled separately.
    function automatic int last_step(input logic [4:0] op);
        case (op)
            ADD, SUB, AND_, OR_, ADDI, LDI: return 5;
            LD, ST:                         return 7;
            BRZR:                           return 6;
            JR, MFHI, MFLO, IN_, OUT_:      return 3;
            default:                        return 2;
        endcase
    endfunction

    // Expected control word for step s of instruction op, written as per-instruction recipes.
    function automatic logic [30:0] expect_ctl(input logic [4:0] op, input int s, input logic con);
        logic [30:0] m;
        m = M_RUN;
        if (s == 0) return m | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
        if (s == 1) return m | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
        if (s == 2) return m | M_MDROUT | M_IRIN;
        case (op)
            ADD, SUB, AND_, OR_: begin
                if (s == 3) m |= M_GRB | M_ROUT | M_YIN;
                if (s == 4) m |= M_GRC | M_ROUT | M_ZIN | alu(op);
                if (s == 5) m |= M_ZLOWOUT | M_GRA | M_RIN;
            end
            ADDI, LDI: begin
                if (s == 3) m |= M_GRB | M_YIN | ((op == LDI) ? M_BAOUT : M_ROUT);
                if (s == 4) m |= M_COUT | M_ZIN | alu(5'b00011);
                if (s == 5) m |= M_ZLOWOUT | M_GRA | M_RIN;
            end
            LD, ST: begin
                if (s == 3) m |= M_GRB | M_BAOUT | M_YIN;
                if (s == 4) m |= M_COUT | M_ZIN | alu(5'b00011);
                if (s == 5) m |= M_ZLOWOUT | M_MARIN;
                if (s == 6) m |= (op == LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
                if (s == 7) m |= (op == LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
            end
            BRZR: begin
                if (s == 3) m |= M_GRA | M_ROUT | M_CONIN;
                if (s == 4) m |= M_PCOUT | M_YIN;
                if (s == 5) m |= M_COUT | M_ZIN | alu(5'b00011);
                if (s == 6) m |= M_ZLOWOUT | (con ? M_PCIN : 31'd0);
            end
            JR:   m |= M_GRA | M_ROUT | M_PCIN;
            MFHI: m |= M_HIOUT | M_GRA | M_RIN;
            MFLO: m |= M_LOWOUT | M_GRA | M_RIN;
            IN_:  m |= M_INPORTOUT | M_GRA | M_RIN;
            OUT_: m |= M_GRA | M_ROUT | M_OUTPORTIN;
            default: ;
        endcase
        return m;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic check(input string name, input logic [30:0] exp);
        n_checks++;
        if (w_ctl !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, w_ctl, exp);
        end
    endtask

    task automatic do_reset();
        Clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0;
        tick(); tick();
        Clear = 1'b1;
        tick();
    endtask

    task automatic count_cycles(input logic [4:0] op, input int exp);
        int n;
        do_reset();
        IR = {op, 27'd0};
        n = 0;
        do begin
            tick(); #1; n++;
        end while (w_ctl !== T0W && n < 20);
        n_checks++;
        if (n != exp) begin
            n_errors++;
            $display("FAIL cycles op=%b got=%0d exp=%0d", op, n, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        con;
        int          step;
        logic [30:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = 32'd0;

        // Reset behaviour
        tick(); #1; check("reset_hold1", 31'd0);
        tick(); #1; check("reset_hold2", 31'd0);
        Clear = 1'b1;
        tick(); #1; check("reset_to_t0", T0W);

        vecs[0]  = '{MFLO, 1'b0, 3, M_RUN | M_LOWOUT | M_GRA | M_RIN};
        vecs[1]  = '{ADD,  1'b0, 4, M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00011)};
        vecs[2]  = '{ADD,  1'b0, 5, M_RUN | M_ZLOWOUT | M_GRA | M_RIN};
        vecs[3]  = '{ST,   1'b0, 6, M_RUN | M_GRA | M_ROUT | M_MDRIN};
        vecs[4]  = '{ST,   1'b0, 7, M_RUN | M_WRITE};
        vecs[5]  = '{BRZR, 1'b0, 6, M_RUN | M_ZLOWOUT};
        vecs[6]  = '{BRZR, 1'b1, 6, M_RUN | M_ZLOWOUT | M_PCIN};
        vecs[7]  = '{LDI,  1'b0, 3, M_RUN | M_GRB | M_BAOUT | M_YIN};
        vecs[8]  = '{LD,   1'b0, 7, M_RUN | M_MDROUT | M_GRA | M_RIN};
        vecs[9]  = '{SUB,  1'b1, 4, M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00100)};
        vecs[10] = '{ADDI, 1'b0, 4, M_RUN | M_COUT | M_ZIN | alu(5'b00011)};
        vecs[11] = '{OUT_, 1'b0, 3, M_RUN | M_GRA | M_ROUT | M_OUTPORTIN};
        vecs[12] = '{BRZR, 1'b0, 3, M_RUN | M_GRA | M_ROUT | M_CONIN};
        vecs[13] = '{LD,   1'b0, 1, M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN};
        vecs[14] = '{IN_,  1'b0, 3, M_RUN | M_INPORTOUT | M_GRA | M_RIN};
        vecs[15] = '{AND_, 1'b0, 2, M_RUN | M_MDROUT | M_IRIN};

        foreach (vecs[i]) begin
            do_reset();
            IR = {vecs[i].op, 27'h155AA};
            for (int s = 0; s < vecs[i].step; s++) tick();
            CON_FF = vecs[i].con;
            #1;
            check($sformatf("vec%0d_op%b_t%0d", i, vecs[i].op, vecs[i].step), vecs[i].exp);
        end

        // Cycle counts from T0 entry to the next T0 entry
        count_cycles(MFLO, 4);
        count_cycles(JR, 4);
        count_cycles(NOP, 3);
        count_cycles(5'b00111, 3);
        count_cycles(ADD, 6);
        count_cycles(LDI, 6);
        count_cycles(LD, 8);
        count_cycles(ST, 8);
        count_cycles(BRZR, 7);

        // Stop raised mid-instruction: add completes, then HALT
        do_reset();
        IR = {ADD, 27'd0};
        for (int s = 0; s < 4; s++) tick();
        Stop = 1'b1;
        #1; check("stop_add_t4", M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00011));
        tick(); #1; check("stop_add_t5", M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        tick(); #1; check("stop_halt", 31'd0);
        Stop = 1'b0;
        tick(); #1; check("halt_sticky", 31'd0);

        // Halt opcode
        do_reset();
        IR = {HALT, 27'd0};
        tick(); tick(); tick(); #1; check("halt_opcode", 31'd0);

        // Clear mid-ld is immediate
        do_reset();
        IR = {LD, 27'd0};
        for (int s = 0; s < 5; s++) tick();
        #1; check("ld_t5", M_RUN | M_ZLOWOUT | M_MARIN);
        Clear = 1'b0;
        #1; check("clear_async", 31'd0);
        tick(); #1; check("clear_hold", 31'd0);

        // Clear and Stop together: Clear wins, RESET still leaves to T0
        Stop = 1'b1;
        #1; check("clear_stop", 31'd0);
        Clear = 1'b1;
        tick(); #1; check("clear_stop_t0", T0W);
        Stop = 1'b0;

        // Randomized instruction stream against the recipe model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [4:0] op;
            logic       halted;
            int         last;
            op     = 5'($urandom_range(0, 31));
            IR     = {op, 27'($urandom)};
            last   = last_step(op);
            halted = (op == HALT);
            for (int s = 0; s <= last; s++) begin
                CON_FF = 1'($urandom);
                Stop   = ($urandom_range(0, 7) == 0);
                #1;
                check($sformatf("rand%0d_op%b_t%0d", n, op, s), expect_ctl(op, s, CON_FF));
                if (s == last && Stop) halted = 1'b1;
                tick();
            end
            Stop = 1'b0;
            if (halted) begin
                #1; check($sformatf("rand%0d_halt", n), 31'd0);
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit for the single-bus datapath. It generates every register-transfer control strobe that testbenches currently drive by hand. It runs the shared 3-step fetch (T0–T2) and then up to 5 execute steps (T3–T7), decoded from the IR opcode. It sits beside the datapath: it consumes IR and CON_FF and drives the datapath control inputs directly.

Parameters:
OP_MSB, 31, top bit of the 5-bit opcode field; opcode = IR[OP_MSB:OP_MSB-4]
ALU_ADD, 5'b00011, ALUop code driven for address, PC-offset and immediate additions
HALT_ON_UNKNOWN, 0, 1 = an undefined opcode enters HALT; 0 = it executes as nop

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  asynchronous reset, active-low
IR  in  32  instruction register contents from the datapath
CON_FF  in  1  branch-condition flip-flop output
Stop  in  1  halt request, sampled at instruction boundary
Run  out  1  1 while executing; 0 in RESET and HALT
ALUop  out  5  ALU operation select, valid while Zin=1
PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout  out  1 each  bus-source enables
MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin  out  1 each  register load enables
IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn  out  1 each  misc datapath controls

Behaviour:
- State register: RESET, T0..T7, HALT.
- Outputs are a combinational decode of (state, opcode, CON_FF) with no extra register stage. At most one bus-source enable is high per state.
- Clear=0 is asynchronous: state goes to RESET immediately, all outputs 0, Run=0, including mid-instruction.
- The first rising edge after Clear releases moves RESET to T0.
- Fetch, common to all opcodes:
  - T0: PCout MARin IncPC Zin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
- At the end of T2 the opcode is taken from the newly loaded IR. Nop (11010), and unknown opcodes when HALT_ON_UNKNOWN=0, go from T2 to T0.
- Execute sequences. The last listed step returns to T0; steps are T3 onward.
  - add 00011, sub 00100, and 00101, or 00110:
    - T3: Grb Rout Yin
    - T4: Grc Rout Zin, ALUop=opcode
    - T5: Zlowout Gra Rin
  - addi 01011 and ldi 00001:
    - T3: Grb Rout Yin (ldi uses BAout in place of Rout)
    - T4: Cout Zin, ALUop=ALU_ADD
    - T5: Zlowout Gra Rin
  - ld 00000:
    - T3: Grb BAout Yin
    - T4: Cout Zin ALU_ADD
    - T5: Zlowout MARin
    - T6: Read MDRin
    - T7: MDRout Gra Rin
  - st 00010:
    - T3–T5 as ld
    - T6: Gra Rout MDRin (Read=0)
    - T7: Write
  - brzr 10010:
    - T3: Gra Rout CONIn
    - T4: PCout Yin
    - T5: Cout Zin ALU_ADD
    - T6: Zlowout, with PCin=CON_FF. CON_FF is sampled combinationally in T6; not taken means no PC load.
  - jr 10011: T3: Gra Rout PCin
  - mfhi 11000: T3: HIout Gra Rin
  - mflo 11001: T3: LOWout Gra Rin
  - in 10110: T3: InPortout Gra Rin
  - out 10111: T3: Gra Rout OutPortin
  - halt 11011: T2 goes to HALT.
- HALT: all outputs 0, Run=0. It is left only via Clear.
- Stop=1 at an edge that would enter T0 from a completion step diverts to HALT instead. Stop is ignored mid-instruction, and the current instruction always completes.
- Stop and Clear asserted together: Clear wins.
- Cycle counts from T0 entry to next T0 entry:
  - ALU/addi/ldi: 6
  - ld/st: 8
  - brzr: 7
  - jr/mf*/in/out: 4
  - nop: 3
- Run=1 in T0..T7.

Test Plan:
- Reset: hold Clear=0 for 2 cycles -> all outputs 0, Run=0. Release -> next edge shows T0 with PCout=MARin=IncPC=Zin=1.
- mflo R2: IR=32'hC9000000 -> T3 has LOWout=Gra=Rin=1 and Rout=0. The next edge returns to T0; 4 cycles total.
- add: IR opcode 00011 -> T4 has Grc=Rout=Zin=1 and ALUop=5'b00011; T5 has Zlowout=Gra=Rin=1.
- st: opcode 00010 -> T6 has MDRin=1 with Read=0; T7 has Write=1 only; 8 cycles total.
- brzr: CON_FF=0 -> T6 has PCin=0. CON_FF=1 -> T6 has PCin=1 and Zlowout=1.
- Control interrupts:
  - Assert Stop during T4 of add -> the instruction completes, then HALT with Run=0.
  - Assert Clear=0 during T5 of ld -> immediate RESET with outputs 0.
